// File: rtl/fp_wire.sv
// Shared types and constants for the floating-point datapath stages.
package fp_wire;

    localparam int unsigned DIV_ITER_S = 27;
    localparam int unsigned DIV_ITER_D = 56;

    typedef struct packed {
        logic        sig;
        logic [13:0] expo;
        logic [53:0] mant;
        logic [1:0]  rema;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic [2:0]  grs;
        logic        snan;
        logic        qnan;
        logic        dbz;
        logic        inf;
        logic        zero;
    } fp_rnd_in_type;

    typedef struct packed {
        logic        a_sig;
        logic [13:0] a_expo;
        logic [52:0] a_mant;
        logic        a_zero, a_inf, a_nan, a_snan;
        logic        b_sig;
        logic [13:0] b_expo;
        logic [52:0] b_mant;
        logic        b_zero, b_inf, b_nan, b_snan;
        logic [1:0]  fmt;
        logic [2:0]  rm;
    } fp_div_in_type;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM,
        ST_DONE
    } fp_div_state_type;

    // Returns {snan, qnan, dbz, inf, zero}; nonzero means the divide loop is skipped.
    function automatic logic [4:0] fp_div_class(input fp_div_in_type op);
        logic snan, qnan, dbz, inf, zero;
        snan = 1'b0;
        qnan = 1'b0;
        dbz  = 1'b0;
        inf  = 1'b0;
        zero = 1'b0;
        if (op.a_nan || op.b_nan || op.a_snan || op.b_snan) begin
            snan = op.a_snan | op.b_snan;
            qnan = ~snan;
        end else if ((op.a_zero && op.b_zero) || (op.a_inf && op.b_inf)) begin
            snan = 1'b1;
        end else if (op.b_zero && !op.a_inf) begin
            dbz = 1'b1;
        end else if (op.a_inf) begin
            inf = 1'b1;
        end else if (op.a_zero || op.b_inf) begin
            zero = 1'b1;
        end
        return {snan, qnan, dbz, inf, zero};
    endfunction

endpackage

// File: rtl/fp_div_norm.sv
// Combinational quotient normalization, subnormal right-shift and sticky collection.
module fp_div_norm
    import fp_wire::*;
(
    input  logic [55:0] q_i,
    input  logic        rem_nz_i,
    input  logic [13:0] expo_i,
    input  logic        dbl_i,
    output logic [53:0] mant_o,
    output logic [2:0]  grs_o,
    output logic [13:0] expo_o
);
    logic [54:0] v_n, v_sh;
    logic        s_n, lost;
    logic [13:0] e_n, e_o;
    logic [14:0] sh_raw;
    logic [5:0]  sh, sh_max;

    always_comb begin
        v_n = '0;
        s_n = rem_nz_i;
        e_n = expo_i;
        // v_n holds {mant, g, r}, right-aligned for single precision.
        if (dbl_i) begin
            if (q_i[55]) begin
                v_n = q_i[55:1];
                s_n = q_i[0] | rem_nz_i;
            end else begin
                v_n = q_i[54:0];
                e_n = expo_i - 14'd1;
            end
        end else begin
            if (q_i[26]) begin
                v_n = {29'b0, q_i[26:1]};
                s_n = q_i[0] | rem_nz_i;
            end else begin
                v_n = {29'b0, q_i[25:0]};
                e_n = expo_i - 14'd1;
            end
        end

        sh_max = dbl_i ? 6'd55 : 6'd26;
        sh_raw = 15'd1 - {e_n[13], e_n};
        sh     = '0;
        e_o    = e_n;
        if ($signed(e_n) <= 14'sd0) begin
            sh  = (sh_raw > {9'b0, sh_max}) ? sh_max : sh_raw[5:0];
            e_o = '0;
        end

        lost   = |(v_n & ~({55{1'b1}} << sh));
        v_sh   = v_n >> sh;
        mant_o = {1'b0, v_sh[54:2]};
        grs_o  = {v_sh[1:0], s_n | lost};
        expo_o = e_o;
    end

endmodule

// File: rtl/fp_div_seq.sv
// Iterative radix-2 restoring FP divider: one quotient bit per cycle, then a single normalize cycle.
module fp_div_seq
    import fp_wire::*;
#(
    parameter int BIAS_S = 127,
    parameter int BIAS_D = 1023
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic          kill,
    input  logic          a_sig,
    input  logic          b_sig,
    input  logic [13:0]   a_expo,
    input  logic [13:0]   b_expo,
    input  logic [52:0]   a_mant,
    input  logic [52:0]   b_mant,
    input  logic          a_zero,
    input  logic          a_inf,
    input  logic          a_nan,
    input  logic          a_snan,
    input  logic          b_zero,
    input  logic          b_inf,
    input  logic          b_nan,
    input  logic          b_snan,
    input  logic [1:0]    fmt,
    input  logic [2:0]    rm,
    output fp_rnd_in_type rnd_o,
    output logic          ready
);
    localparam logic [13:0] BIAS_S14 = 14'(BIAS_S);
    localparam logic [13:0] BIAS_D14 = 14'(BIAS_D);

    fp_div_state_type state_q, state_d;
    fp_div_in_type    op;
    fp_rnd_in_type    hdr_q, hdr_d, rnd_q, rnd_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [55:0]      q_q, q_d, rem_q, rem_d, dext;
    logic [52:0]      d_q, d_d;
    logic [4:0]       cls;
    logic             special, dbl_in;
    logic [53:0]      n_mant;
    logic [2:0]       n_grs;
    logic [13:0]      n_expo;

    always_comb begin
        op.a_sig  = a_sig;   op.a_expo = a_expo;  op.a_mant = a_mant;
        op.a_zero = a_zero;  op.a_inf  = a_inf;   op.a_nan  = a_nan;   op.a_snan = a_snan;
        op.b_sig  = b_sig;   op.b_expo = b_expo;  op.b_mant = b_mant;
        op.b_zero = b_zero;  op.b_inf  = b_inf;   op.b_nan  = b_nan;   op.b_snan = b_snan;
        op.fmt    = fmt;     op.rm     = rm;
    end

    assign cls     = fp_div_class(op);
    assign special = |cls;
    assign dbl_in  = (op.fmt == 2'd1);
    assign dext    = {3'b0, d_q};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (enable) state_d = special ? ST_NORM : ST_DIV;
            ST_DIV:  if (cnt_q == 6'd1) state_d = ST_NORM;
            ST_NORM: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (kill) state_d = ST_IDLE;
    end

    always_comb begin
        ready = (state_q == ST_DONE) && !kill;
    end

    always_comb begin
        cnt_d = cnt_q;
        q_d   = q_q;
        rem_d = rem_q;
        d_d   = d_q;
        hdr_d = hdr_q;
        rnd_d = rnd_q;
        unique case (state_q)
            ST_IDLE: if (enable && !kill) begin
                hdr_d      = '0;
                hdr_d.sig  = op.a_sig ^ op.b_sig;
                hdr_d.expo = op.a_expo - op.b_expo + (dbl_in ? BIAS_D14 : BIAS_S14);
                hdr_d.fmt  = op.fmt;
                hdr_d.rm   = op.rm;
                {hdr_d.snan, hdr_d.qnan, hdr_d.dbz, hdr_d.inf, hdr_d.zero} = cls;
                q_d   = '0;
                rem_d = {3'b0, op.a_mant};
                d_d   = op.b_mant;
                cnt_d = special ? 6'd0 : (dbl_in ? 6'(DIV_ITER_D) : 6'(DIV_ITER_S));
            end
            ST_DIV: begin
                if (rem_q >= dext) begin
                    q_d   = {q_q[54:0], 1'b1};
                    rem_d = (rem_q - dext) << 1;
                end else begin
                    q_d   = {q_q[54:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q - 6'd1;
            end
            ST_NORM: if (!kill) begin
                rnd_d      = hdr_q;
                rnd_d.mant = n_mant;
                rnd_d.grs  = n_grs;
                rnd_d.expo = n_expo;
                rnd_d.rema = 2'b00;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            q_q   <= '0;
            rem_q <= '0;
            d_q   <= '0;
            hdr_q <= '0;
            rnd_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            q_q   <= q_d;
            rem_q <= rem_d;
            d_q   <= d_d;
            hdr_q <= hdr_d;
            rnd_q <= rnd_d;
        end
    end

    fp_div_norm u_norm (
        .q_i      (q_q),
        .rem_nz_i (|rem_q),
        .expo_i   (hdr_q.expo),
        .dbl_i    (hdr_q.fmt == 2'd1),
        .mant_o   (n_mant),
        .grs_o    (n_grs),
        .expo_o   (n_expo)
    );

    assign rnd_o = rnd_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed vector table, random ops against an arithmetic model, kill/reset sequences.
module tb_fp_div_seq;
    import fp_wire::*;

    logic          clock = 1'b0;
    logic          reset, enable, kill;
    logic          a_sig, b_sig, a_zero, a_inf, a_nan, a_snan, b_zero, b_inf, b_nan, b_snan;
    logic [13:0]   a_expo, b_expo;
    logic [52:0]   a_mant, b_mant;
    logic [1:0]    fmt;
    logic [2:0]    rm;
    fp_rnd_in_type rnd_o;
    logic          ready;

    always #5 clock = ~clock;

    fp_div_seq #(.BIAS_S(127), .BIAS_D(1023)) dut (
        .clock(clock), .reset(reset), .enable(enable), .kill(kill),
        .a_sig(a_sig), .b_sig(b_sig), .a_expo(a_expo), .b_expo(b_expo),
        .a_mant(a_mant), .b_mant(b_mant),
        .a_zero(a_zero), .a_inf(a_inf), .a_nan(a_nan), .a_snan(a_snan),
        .b_zero(b_zero), .b_inf(b_inf), .b_nan(b_nan), .b_snan(b_snan),
        .fmt(fmt), .rm(rm), .rnd_o(rnd_o), .ready(ready)
    );

    localparam logic [52:0] ONE  = 53'h10000000000000;
    localparam logic [52:0] P5   = 53'h18000000000000;
    localparam logic [3:0]  NUM  = 4'b0000;  // class = {zero, inf, nan, snan}
    localparam logic [3:0]  ZERO = 4'b1000;
    localparam logic [3:0]  INF  = 4'b0100;
    localparam logic [3:0]  QNAN = 4'b0010;
    localparam logic [3:0]  SNAN = 4'b0011;

    typedef struct {
        logic        dbl;
        logic        as;
        logic [13:0] ae;
        logic [52:0] am;
        logic [3:0]  ac;
        logic        bs;
        logic [13:0] be;
        logic [52:0] bm;
        logic [3:0]  bc;
        logic [2:0]  rm;
        int          lat;
        logic [13:0] e_expo;
        logic [53:0] e_mant;
        logic [2:0]  e_grs;
        logic        e_sig;
        logic [4:0]  e_flags;
        bit          chk_num;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic vec_t mkv(input logic dbl, input logic as, input logic [13:0] ae,
                                 input logic [52:0] am, input logic [3:0] ac,
                                 input logic bs, input logic [13:0] be, input logic [52:0] bm,
                                 input logic [3:0] bc, input int lat, input logic [13:0] ee,
                                 input logic [53:0] em, input logic [2:0] eg, input logic es,
                                 input logic [4:0] ef, input bit chk);
        vec_t v;
        v.dbl = dbl; v.as = as; v.ae = ae; v.am = am; v.ac = ac;
        v.bs = bs; v.be = be; v.bm = bm; v.bc = bc; v.rm = 3'd0;
        v.lat = lat; v.e_expo = ee; v.e_mant = em; v.e_grs = eg; v.e_sig = es;
        v.e_flags = ef; v.chk_num = chk;
        return v;
    endfunction

    // Quotient as exact integer division; rounding bits and subnormal shift from plain arithmetic.
    function automatic void ref_div(input logic dbl, input logic [13:0] ae, input logic [13:0] be,
                                    input logic [52:0] am, input logic [52:0] bm,
                                    output logic [13:0] eo, output logic [53:0] mo,
                                    output logic [2:0] go);
        int n, e, sh;
        logic [127:0] num, q, keep;
        bit st;
        n   = dbl ? 56 : 27;
        num = 128'(am) << (n - 1);
        q   = num / 128'(bm);
        st  = (num % 128'(bm)) != 0;
        e   = int'($signed(ae)) - int'($signed(be)) + (dbl ? 1023 : 127);
        if ((q >> (n - 1)) != 0) begin
            st   = st | q[0];
            keep = q >> 1;
        end else begin
            keep = q;
            e    = e - 1;
        end
        if (e <= 0) begin
            sh = 1 - e;
            if (sh > n - 1) sh = n - 1;
            if ((keep % (128'd1 << sh)) != 0) st = 1'b1;
            keep = keep >> sh;
            e    = 0;
        end
        eo = 14'(e);
        mo = 54'(keep >> 2);
        go = {keep[1], keep[0], st};
    endfunction

    task automatic drive(input vec_t v);
        fmt = {1'b0, v.dbl};
        rm  = v.rm;
        a_sig = v.as; a_expo = v.ae; a_mant = v.am; {a_zero, a_inf, a_nan, a_snan} = v.ac;
        b_sig = v.bs; b_expo = v.be; b_mant = v.bm; {b_zero, b_inf, b_nan, b_snan} = v.bc;
    endtask

    // Starts in IDLE at #1 after an edge; returns at #1 after the edge following DONE.
    task automatic run_op(input vec_t v, output int lat, output fp_rnd_in_type res);
        drive(v);
        enable = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        lat = 1;
        while (!ready && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!ready) lat = -1;
        res = rnd_o;
        @(posedge clock); #1;
        check("ready_pulse", 64'(ready), 64'd0);
        check("rnd_hold", 64'(rnd_o == res), 64'd1);
    endtask

    task automatic compare(input string tag, input vec_t v, input int lat, input fp_rnd_in_type r);
        check({tag, ".lat"}, 64'(lat), 64'(v.lat));
        check({tag, ".flags"}, 64'({r.snan, r.qnan, r.dbz, r.inf, r.zero}), 64'(v.e_flags));
        check({tag, ".sig"}, 64'(r.sig), 64'(v.e_sig));
        check({tag, ".fmt"}, 64'(r.fmt), 64'({1'b0, v.dbl}));
        check({tag, ".rm"}, 64'(r.rm), 64'(v.rm));
        if (v.chk_num) begin
            check({tag, ".expo"}, 64'(r.expo), 64'(v.e_expo));
            check({tag, ".mant"}, 64'(r.mant), 64'(v.e_mant));
            check({tag, ".grs"}, 64'(r.grs), 64'(v.e_grs));
            check({tag, ".rema"}, 64'(r.rema), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[16];
        vec_t          v;
        int            lat, n;
        fp_rnd_in_type res;

        tbl[0]  = mkv(0, 0, 127, P5,  NUM,  0, 127, ONE, NUM,  29, 127,  54'hC00000, 3'b000, 0, 5'b00000, 1);
        tbl[1]  = mkv(0, 0, 127, ONE, NUM,  0, 128, P5,  NUM,  29, 125,  54'hAAAAAA, 3'b101, 0, 5'b00000, 1);
        tbl[2]  = mkv(0, 0, 1,   ONE, NUM,  0, 130, ONE, NUM,  29, 0,    54'h100000, 3'b000, 0, 5'b00000, 1);
        tbl[3]  = mkv(1, 0, 1023, ONE, NUM, 0, 1024, P5, NUM,  58, 1021, 54'h15555555555555, 3'b011, 0, 5'b00000, 1);
        tbl[4]  = mkv(1, 0, 1023, P5, NUM,  0, 1023, ONE, NUM, 58, 1023, 54'h18000000000000, 3'b000, 0, 5'b00000, 1);
        tbl[5]  = mkv(0, 0, 1,   ONE, NUM,  0, 127, ONE, NUM,  29, 1,    54'h800000, 3'b000, 0, 5'b00000, 1);
        tbl[6]  = mkv(0, 0, 1,   ONE, NUM,  0, 128, ONE, NUM,  29, 0,    54'h400000, 3'b000, 0, 5'b00000, 1);
        tbl[7]  = mkv(0, 0, 1,   ONE, NUM,  0, 254, ONE, NUM,  29, 0,    54'h0,      3'b001, 0, 5'b00000, 1);
        tbl[8]  = mkv(0, 0, 127, ONE, NUM,  0, 0,   '0,  ZERO, 2,  0, '0, '0, 0, 5'b00100, 0);
        tbl[9]  = mkv(0, 0, 0,   '0,  ZERO, 0, 0,   '0,  ZERO, 2,  0, '0, '0, 0, 5'b10000, 0);
        tbl[10] = mkv(0, 1, 255, ONE, INF,  0, 128, ONE, NUM,  2,  0, '0, '0, 1, 5'b00010, 0);
        tbl[11] = mkv(0, 0, 255, P5,  QNAN, 0, 127, ONE, NUM,  2,  0, '0, '0, 0, 5'b01000, 0);
        tbl[12] = mkv(1, 1, 1023, ONE, NUM, 0, 2047, ONE, INF, 2,  0, '0, '0, 1, 5'b00001, 0);
        tbl[13] = mkv(0, 0, 127, ONE, NUM,  1, 255, P5,  SNAN, 2,  0, '0, '0, 1, 5'b10000, 0);
        tbl[14] = mkv(1, 0, 2047, ONE, INF, 1, 2047, ONE, INF, 2,  0, '0, '0, 1, 5'b10000, 0);
        tbl[15] = mkv(0, 1, 0,   '0,  ZERO, 1, 129, P5,  NUM,  2,  0, '0, '0, 0, 5'b00001, 0);
        for (int i = 0; i < 16; i++) tbl[i].rm = 3'(i % 5);

        reset = 1'b1; enable = 1'b0; kill = 1'b0;
        drive(tbl[0]);
        repeat (2) @(posedge clock);
        #1;
        check("reset.ready", 64'(ready), 64'd0);
        check("reset.rnd_lo", rnd_o[63:0], 64'd0);
        check("reset.rnd_hi", 64'(rnd_o[$bits(fp_rnd_in_type)-1:64]), 64'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        for (int i = 0; i < 16; i++) begin
            run_op(tbl[i], lat, res);
            compare($sformatf("dir%0d", i), tbl[i], lat, res);
        end

        for (int i = 0; i < 40; i++) begin
            v = mkv(1'($urandom_range(0, 1)), 1'($urandom), 0, '0, NUM, 1'($urandom), 0, '0, NUM,
                    0, 0, '0, '0, 0, 5'b00000, 1);
            if (v.dbl) begin
                v.am = {1'b1, 20'($urandom), $urandom};
                v.bm = {1'b1, 20'($urandom), $urandom};
                v.ae = 14'($urandom_range(1, 2046));
                v.be = 14'($urandom_range(1, 2046));
                v.lat = 58;
            end else begin
                v.am = {1'b1, 23'($urandom), 29'b0};
                v.bm = {1'b1, 23'($urandom), 29'b0};
                v.ae = 14'($urandom_range(1, 254));
                v.be = 14'($urandom_range(1, 254));
                v.lat = 29;
            end
            v.rm = 3'($urandom_range(0, 4));
            v.e_sig = v.as ^ v.bs;
            ref_div(v.dbl, v.ae, v.be, v.am, v.bm, v.e_expo, v.e_mant, v.e_grs);
            run_op(v, lat, res);
            compare($sformatf("rnd%0d", i), v, lat, res);
        end

        drive(tbl[1]);
        enable = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        kill = 1'b1;
        @(posedge clock); #1;
        kill = 1'b0;
        check("kill.ready", 64'(ready), 64'd0);
        run_op(tbl[0], lat, res);
        compare("kill_next", tbl[0], lat, res);

        drive(tbl[0]);
        enable = 1'b1;
        kill   = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        kill   = 1'b0;
        n = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (ready) n++;
        end
        check("kill_prio.readys", 64'(n), 64'd0);

        drive(tbl[3]);
        enable = 1'b1;
        @(posedge clock); #1;
        enable = 1'b0;
        repeat (8) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        check("midreset.ready", 64'(ready), 64'd0);
        check("midreset.rnd_lo", rnd_o[63:0], 64'd0);
        check("midreset.rnd_hi", 64'(rnd_o[$bits(fp_rnd_in_type)-1:64]), 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        run_op(tbl[1], lat, res);
        compare("after_reset", tbl[1], lat, res);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
